mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port mem_unit between NUM_REQ requesters.
- Each cycle it grants at most one request and forwards that request's command fields to the memory port.
- It tracks in-flight reads through a LATENCY-deep tag pipeline and returns read data to the originating requester with a one-cycle valid strobe.
- Sits between the core or DMA masters and mem_unit in the memory subsystem.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- NUM_WORDS, 64, words in the attached memory.
- DATA_WIDTH, 32, word width in bits.
- BYTE_WIDTH, 8, byte width in bits.
- LATENCY, 1, memory read latency in cycles (>=1); must match the mem_unit instance.
- ADDR_WIDTH, $clog2(NUM_WORDS), derived; do not override.
- NUM_BYTES, DATA_WIDTH/BYTE_WIDTH, derived; byte-enable width.
- ID_WIDTH, $clog2(NUM_REQ), derived.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  per-requester request.
- w_en_i  in  NUM_REQ  per-requester write enable (1=write, 0=read).
- addr_i  in  NUM_REQ x ADDR_WIDTH  per-requester word address.
- w_data_i  in  NUM_REQ x DATA_WIDTH  per-requester write data.
- b_en_i  in  NUM_REQ x NUM_BYTES  per-requester byte enables.
- gnt_o  out  NUM_REQ  one-hot grant, combinational, same cycle as the request.
- r_valid_o  out  NUM_REQ  one-hot read-data-valid strobe.
- r_data_o  out  DATA_WIDTH  read data, shared by all requesters; qualified by r_valid_o.
- mem_req_o  out  1  memory request.
- mem_w_en_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_w_data_o  out  DATA_WIDTH  memory write data.
- mem_b_en_o  out  NUM_BYTES  memory byte enables.
- mem_r_data_i  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset (async, rst_ni=0):
  - Priority pointer clears to 0.
  - Tag pipeline clears: all valid bits 0, ids 0.
  - r_valid_o=0 immediately.
  - gnt_o and mem_* depend only on req_i; with req_i=0 they are all 0.
- Arbitration (combinational):
  - The winner is the first set bit of req_i, searching from ptr upward and wrapping modulo NUM_REQ.
  - gnt_o has exactly the winner's bit set, or is 0 if req_i=0.
  - mem_req_o = |req_i.
  - mem_w_en_o, mem_addr_o, mem_w_data_o and mem_b_en_o mux the winner's fields.
  - With no winner, all mem_* outputs are 0.
- Pointer update:
  - On a clock edge with a grant, ptr <= winner+1, wrapping to 0 after NUM_REQ-1.
  - With no grant, ptr holds.
- Handshake:
  - A requester holds req_i and its fields stable until it sees gnt_o.
  - A transaction completes on the edge where gnt_o is high.
  - A requester may re-request back-to-back.
  - Under continuous requests from all requesters, each is granted once every NUM_REQ cycles (no starvation).
- Read tracking:
  - Stage 0 of the tag pipeline captures {valid = grant & ~w_en, id = winner} on every edge.
  - The pipeline shifts one stage per cycle and is LATENCY deep.
  - A read granted at edge T produces data on mem_r_data_i during cycle T+LATENCY. In that cycle r_valid_o[id]=1 for exactly one cycle and r_data_o=mem_r_data_i.
  - r_data_o is a combinational passthrough of mem_r_data_i; its value while r_valid_o=0 is don't-care.
- Writes:
  - Granted writes never generate r_valid_o.
  - A write followed by a read to the same address in the next cycle returns the new data, since mem_unit writes on the grant edge.
- Pipelining:
  - One new grant per cycle regardless of outstanding reads.
  - Up to LATENCY reads may be in flight; returns arrive in grant order.
- Edge cases:
  - Simultaneous requests: resolved only by ptr, so no requester has fixed priority.
  - ptr pointing at an idle requester: the search skips it.
  - Reset asserted mid-operation: in-flight reads are dropped and produce no r_valid_o. Requesters must reissue after reset.
  - NUM_REQ not a power of 2: the ptr wrap must be explicit; no modulo-by-width truncation.

Test Plan:
- Reset, then req_i=4'b0000 for 5 cycles -> gnt_o=0, mem_req_o=0, r_valid_o=0 throughout.
- Single requester: req_i=4'b0100, write addr 5, data 32'hDEADBEEF, b_en=4'hF, then read addr 5 -> gnt_o=4'b0100 both cycles; r_valid_o=4'b0100 with r_data_o=32'hDEADBEEF exactly LATENCY cycles after the read grant.
- Fairness: req_i=4'b1111 held 8 cycles from ptr=0 -> grant order 0,1,2,3,0,1,2,3.
- Skip idle: ptr=1, req_i=4'b1001 -> grant goes to requester 3; next cycle, requester 0.
- Back-to-back reads: requester 1 reads addr 2, then requester 2 reads addr 3 in the next cycle (gold data A, B) -> r_valid_o=4'b0010 with A, then 4'b0100 with B, on consecutive cycles. Repeat with LATENCY=3.
- Reset mid-read: read granted, rst_ni=0 before the data returns -> r_valid_o stays 0. After release, ptr=0 and a fresh read returns correct data.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
// Read returns are routed back to their requester via a LATENCY-deep tag pipeline.
module mem_rr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int NUM_WORDS  = 64,
    parameter  int DATA_WIDTH = 32,
    parameter  int BYTE_WIDTH = 8,
    parameter  int LATENCY    = 1,
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS),
    localparam int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_REQ-1:0]                   req_i,
    input  logic [NUM_REQ-1:0]                   w_en_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   w_data_i,
    input  logic [NUM_REQ-1:0][NUM_BYTES-1:0]    b_en_i,
    output logic [NUM_REQ-1:0]                   gnt_o,
    output logic [NUM_REQ-1:0]                   r_valid_o,
    output logic [DATA_WIDTH-1:0]                r_data_o,
    output logic                                 mem_req_o,
    output logic                                 mem_w_en_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic [DATA_WIDTH-1:0]                mem_w_data_o,
    output logic [NUM_BYTES-1:0]                 mem_b_en_o,
    input  logic [DATA_WIDTH-1:0]                mem_r_data_i
);

    logic [ID_WIDTH-1:0]               r_ptr;
    logic [LATENCY-1:0]                r_vld_pipe;
    logic [LATENCY-1:0][ID_WIDTH-1:0]  r_id_pipe;
    logic [ID_WIDTH-1:0]               w_win;
    logic                              w_any;
    logic [ID_WIDTH-1:0]               w_ptr_nxt;

    // Scan downward so the last hit is the closest requester at or after r_ptr.
    always_comb begin
        int idx;
        w_any = 1'b0;
        w_win = '0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_i[idx]) begin
                w_any = 1'b1;
                w_win = ID_WIDTH'(idx);
            end
        end
    end

    // Explicit wrap keeps non-power-of-two NUM_REQ correct.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_any) begin
            if (w_win == ID_WIDTH'(NUM_REQ - 1)) w_ptr_nxt = '0;
            else                                 w_ptr_nxt = w_win + ID_WIDTH'(1);
        end
    end

    always_comb begin
        gnt_o        = '0;
        mem_req_o    = w_any;
        mem_w_en_o   = 1'b0;
        mem_addr_o   = '0;
        mem_w_data_o = '0;
        mem_b_en_o   = '0;
        if (w_any) begin
            gnt_o[w_win] = 1'b1;
            mem_w_en_o   = w_en_i[w_win];
            mem_addr_o   = addr_i[w_win];
            mem_w_data_o = w_data_i[w_win];
            mem_b_en_o   = b_en_i[w_win];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_vld_pipe <= '0;
            r_id_pipe  <= '0;
        end else begin
            r_ptr         <= w_ptr_nxt;
            r_vld_pipe[0] <= w_any & ~w_en_i[w_win];
            r_id_pipe[0]  <= w_win;
            for (int s = 1; s < LATENCY; s++) begin
                r_vld_pipe[s] <= r_vld_pipe[s-1];
                r_id_pipe[s]  <= r_id_pipe[s-1];
            end
        end
    end

    always_comb begin
        r_valid_o = '0;
        if (r_vld_pipe[LATENCY-1]) r_valid_o[r_id_pipe[LATENCY-1]] = 1'b1;
    end

    assign r_data_o = mem_r_data_i;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter: two DUTs (LATENCY 1 and 3) share stimulus,
// each with its own memory model and read-return monitor.
module tb_mem_rr_arbiter;
    localparam int N  = 4;
    localparam int NW = 64;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NB = 4;

    typedef struct {
        int            id;
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]         req, wen;
    logic [N-1:0][AW-1:0] addr;
    logic [N-1:0][DW-1:0] wdata;
    logic [N-1:0][NB-1:0] ben;

    logic [N-1:0]  gnt_a [2];
    logic [N-1:0]  rv_a [2];
    logic [DW-1:0] rdata_a [2];
    logic [DW-1:0] mwd_a [2];
    logic [DW-1:0] mrd_a [2];
    logic          mreq_a [2];
    logic          mwen_a [2];
    logic [AW-1:0] maddr_a [2];
    logic [NB-1:0] mben_a [2];

    exp_t          q [2][$];
    int            cyc   = 0;
    int            nchk  = 0;
    int            nfail = 0;
    int            ptr   = 0;
    logic [DW-1:0] gold [NW];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(int i);
        return (DW'(i) * 32'h01030507) ^ 32'h5A5A0000;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] ex);
        nchk++;
        if (act !== ex) begin
            nfail++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, ex, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gl
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [DW-1:0] mem [NW];
        logic [DW-1:0] rp [LAT];

        initial for (int i = 0; i < NW; i++) mem[i] = init_word(i);

        mem_rr_arbiter #(.NUM_REQ(N), .NUM_WORDS(NW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
                         .LATENCY(LAT)) dut (
            .clk_i(clk), .rst_ni(rst_n), .req_i(req), .w_en_i(wen), .addr_i(addr),
            .w_data_i(wdata), .b_en_i(ben), .gnt_o(gnt_a[g]), .r_valid_o(rv_a[g]),
            .r_data_o(rdata_a[g]), .mem_req_o(mreq_a[g]), .mem_w_en_o(mwen_a[g]),
            .mem_addr_o(maddr_a[g]), .mem_w_data_o(mwd_a[g]), .mem_b_en_o(mben_a[g]),
            .mem_r_data_i(mrd_a[g]));

        // Behavioural single-port memory: writes on the request edge, reads LAT cycles later.
        always @(posedge clk) begin
            if (mreq_a[g] && mwen_a[g])
                for (int b = 0; b < NB; b++)
                    if (mben_a[g][b]) mem[maddr_a[g]][b*8 +: 8] <= mwd_a[g][b*8 +: 8];
            rp[0] <= mem[maddr_a[g]];
            for (int s = 1; s < LAT; s++) rp[s] <= rp[s-1];
        end
        assign mrd_a[g] = rp[LAT-1];

        always @(negedge clk) begin
            exp_t        e;
            logic [N-1:0] ev;
            ev = '0;
            if (q[g].size() != 0 && q[g][0].due <= cyc) begin
                e  = q[g].pop_front();
                ev = N'(1) << e.id;
                chk($sformatf("rdata_L%0d", LAT), 64'(rdata_a[g]), 64'(e.d));
            end
            chk($sformatf("r_valid_L%0d", LAT), 64'(rv_a[g]), 64'(ev));
        end
    end

    // One cycle: compare arbitration against the reference, update the model, advance.
    task automatic step(output int w);
        logic [N-1:0] eg;
        @(negedge clk);
        w = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (req[i] && w < 0) w = i;
        end
        eg = (w >= 0) ? (N'(1) << w) : '0;
        for (int g = 0; g < 2; g++) begin
            chk("gnt", 64'(gnt_a[g]), 64'(eg));
            chk("mem_req", 64'(mreq_a[g]), 64'(req != '0));
            if (w >= 0) begin
                chk("mem_w_en", 64'(mwen_a[g]), 64'(wen[w]));
                chk("mem_addr", 64'(maddr_a[g]), 64'(addr[w]));
                if (wen[w]) begin
                    chk("mem_w_data", 64'(mwd_a[g]), 64'(wdata[w]));
                    chk("mem_b_en", 64'(mben_a[g]), 64'(ben[w]));
                end
            end else begin
                chk("mem_idle", 64'({mwen_a[g], maddr_a[g], mwd_a[g], mben_a[g]}), 64'(0));
            end
        end
        if (w >= 0 && rst_n) begin
            ptr = (w + 1) % N;
            if (wen[w]) begin
                for (int b = 0; b < NB; b++)
                    if (ben[w][b]) gold[addr[w]][b*8 +: 8] = wdata[w][b*8 +: 8];
            end else begin
                for (int g = 0; g < 2; g++) begin
                    exp_t e;
                    e.id  = w;
                    e.d   = gold[addr[w]];
                    e.due = cyc + ((g == 0) ? 1 : 3);
                    q[g].push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic steps(int n);
        int w;
        for (int i = 0; i < n; i++) step(w);
    endtask

    task automatic newreq(int i);
        req[i]   = 1'b1;
        wen[i]   = 1'($urandom_range(0, 1));
        addr[i]  = AW'($urandom_range(0, 7));
        wdata[i] = $urandom;
        ben[i]   = NB'($urandom);
    endtask

    initial begin
        int w;
        for (int i = 0; i < NW; i++) gold[i] = init_word(i);
        req = '0; wen = '0; addr = '0; wdata = '0; ben = '0;
        steps(2);
        rst_n = 1'b1;

        steps(5);

        req = 4'b1111;
        for (int i = 0; i < N; i++) addr[i] = AW'(i + 8);
        steps(8);

        req = 4'b0001; steps(1);
        req = 4'b1001; steps(2);
        req = '0;      steps(3);

        req = 4'b0100; wen[2] = 1'b1; addr[2] = 6'd5; wdata[2] = 32'hDEADBEEF; ben[2] = 4'hF;
        steps(1);
        wen[2] = 1'b0; steps(1);
        req = '0;      steps(4);

        req = 4'b0010; wen = '0; addr[1] = 6'd2; steps(1);
        req = 4'b0100; addr[2] = 6'd3; steps(1);
        req = '0;      steps(4);

        req = 4'b0001; addr[0] = 6'd4; steps(1);
        req = '0;
        rst_n = 1'b0;
        q[0].delete(); q[1].delete();
        ptr = 0;
        steps(3);
        rst_n = 1'b1;
        req = 4'b0011; addr[0] = 6'd5; addr[1] = 6'd2; steps(1);
        req[0] = 1'b0; steps(1);
        req = '0;      steps(4);

        for (int c = 0; c < 400; c++) begin
            step(w);
            for (int i = 0; i < N; i++) begin
                if (i == w) begin
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
                    else newreq(i);
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    newreq(i);
                end
            end
        end
        req = '0;
        steps(6);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
